if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the pipelined MIPS-subset CPU. It sits directly upstream of the decode stage.
- Holds the word-addressed PC and drives the combinational instruction ROM address.
- Presents {ins, PC, valid} to decode.
- Implements stall, flush/redirect, a 3-source edge-captured interrupt entry with EPC, and ERET return.

---
 rtl/if_stage.sv | 187 ++++++++++++++++++
 tb/tb_if_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage : instruction fetch stage with IF/ID pipeline register
//
// Holds the word-addressed PC, drives the combinational ROM address and
// registers {ins, pc, valid} toward decode. Handles the following events:
// - stall
// - redirect
// - edge-captured interrupt entry, which saves the return address in EPC
// - ERET return
// - halt
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   rom_addr_o      fetch address (PC register)
//   ins_i           ROM data for rom_addr_o, same cycle
//   stall_i         decode hazard stall
//   redir_i         taken branch/jump resolved downstream
//   redir_pc_i      redirect target
//   eret_i          ERET decoded in ID
//   halt_i          halt syscall decoded
//   irq_i           interrupt request lines (level, same clock)
//   ins_o, pc_o     instruction and its PC toward ID
//   valid_o         ins_o is a real instruction
//   epc_o           saved return address
//   int_en_o        global interrupt enable
//   irq_ack_o       one-hot, one-cycle acknowledge of a taken source
//
// Optional feature (macro IRQ_MASK_EN):
//   Adds mask_we_i / mask_i and a per-source mask register (reset all-ones).
//   Masked sources still latch pending but are not eligible to be taken.
// ----------------------------------------------------------------------------
module if_stage #(
  parameter int unsigned       PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter int unsigned       IRQ_N    = 3,
  parameter logic [31:0]       VEC_BASE = 32'h0000_0100
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   rom_addr_o,
  input  logic [31:0]       ins_i,
  input  logic              stall_i,
  input  logic              redir_i,
  input  logic [PC_W-1:0]   redir_pc_i,
  input  logic              eret_i,
  input  logic              halt_i,
  input  logic [IRQ_N-1:0]  irq_i,
`ifdef IRQ_MASK_EN
  input  logic              mask_we_i,
  input  logic [IRQ_N-1:0]  mask_i,
`endif
  output logic [31:0]       ins_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              valid_o,
  output logic [PC_W-1:0]   epc_o,
  output logic              int_en_o,
  output logic [IRQ_N-1:0]  irq_ack_o
);

  localparam logic [PC_W-1:0] VEC = PC_W'(VEC_BASE);

  logic [PC_W-1:0]  pc_p0;
  logic [31:0]      ins_p1;
  logic [PC_W-1:0]  pc_p1;
  logic             vld_p1;
  logic [PC_W-1:0]  epc_q;
  logic             int_en_q;
  logic [IRQ_N-1:0] ack_q;
  logic [IRQ_N-1:0] pend_q;
  logic [IRQ_N-1:0] irq_prev;
  logic             halted_q;
  logic [1:0]       shadow_q;

  logic [IRQ_N-1:0] rise;
  logic [IRQ_N-1:0] elig;
  logic [IRQ_N-1:0] take_oh;
  logic [PC_W-1:0]  take_sel;
  logic             do_halt, do_redir, shadow_epc, do_eret, do_take;

`ifdef IRQ_MASK_EN
  logic [IRQ_N-1:0] mask_q;

  always_ff @(posedge clk) begin
    if (!rst)
      mask_q <= '1;
    else if (mask_we_i)
      mask_q <= mask_i;
  end

  assign elig = pend_q & mask_q;
`else
  assign elig = pend_q;
`endif

  assign rise = irq_i & ~irq_prev;

  // Lowest set index wins: scan high to low so the last hit is the lowest.
  always_comb begin
    take_oh  = '0;
    take_sel = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        take_oh    = '0;
        take_oh[i] = 1'b1;
        take_sel   = PC_W'(i);
      end
    end
  end

  // Priority chain: halt > redirect > eret > interrupt > stall > sequential.
  // Inside the shadow window a redirect is older than the interrupt that
  // was just taken, so it retargets EPC instead of the PC.
  always_comb begin
    do_halt    = halted_q | halt_i;
    do_redir   = !do_halt && redir_i && (shadow_q == 2'd0);
    shadow_epc = !do_halt && redir_i && (shadow_q != 2'd0);
    do_eret    = !do_halt && !do_redir && eret_i && !stall_i && (shadow_q == 2'd0);
    do_take    = !do_halt && !do_redir && !do_eret && int_en_q && (|elig) && !stall_i;
  end

  // Edge detector history: sampled every cycle, including reset cycles.
  always_ff @(posedge clk) begin
    irq_prev <= irq_i;
  end

  // ---- stage p0 -> p1 : PC update and IF/ID register ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_p0    <= RESET_PC;
      ins_p1   <= '0;
      pc_p1    <= '0;
      vld_p1   <= 1'b0;
      epc_q    <= '0;
      int_en_q <= 1'b1;
      ack_q    <= '0;
      pend_q   <= '0;
      halted_q <= 1'b0;
      shadow_q <= 2'd0;
    end else begin
      // A coinciding new edge re-arms the source that is being acknowledged.
      pend_q   <= (pend_q & ~(do_take ? take_oh : '0)) | rise;
      ack_q    <= do_take ? take_oh : '0;
      shadow_q <= do_take ? 2'd2 : ((shadow_q != 2'd0) ? shadow_q - 2'd1 : 2'd0);

      if (do_halt)
        halted_q <= 1'b1;

      if (shadow_epc)
        epc_q <= redir_pc_i;
      else if (do_take)
        epc_q <= pc_p0;

      if (do_eret)
        int_en_q <= 1'b1;
      else if (do_take)
        int_en_q <= 1'b0;

      if (do_halt || do_redir || do_eret || do_take) begin
        ins_p1 <= '0;
        pc_p1  <= '0;
        vld_p1 <= 1'b0;
      end else if (!stall_i) begin
        ins_p1 <= ins_i;
        pc_p1  <= pc_p0;
        vld_p1 <= 1'b1;
      end

      if (do_redir)
        pc_p0 <= redir_pc_i;
      else if (do_eret)
        pc_p0 <= epc_q;
      else if (do_take)
        pc_p0 <= VEC + take_sel;
      else if (!do_halt && !stall_i)
        pc_p0 <= pc_p0 + 1'b1;
    end
  end

  assign rom_addr_o = pc_p0;
  assign ins_o      = ins_p1;
  assign pc_o       = pc_p1;
  assign valid_o    = vld_p1;
  assign epc_o      = epc_q;
  assign int_en_o   = int_en_q;
  assign irq_ack_o  = ack_q;

endmodule

// File: tb/tb_if_stage.sv
// ----------------------------------------------------------------------------
// tb_if_stage : scoreboard bench for if_stage.
// A driver applies directed then random stimulus on the falling edge. It
// advances a behavioural model of the fetch stage and queues the outputs
// expected after the next rising edge. A monitor pops one entry per cycle
// and compares it with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_if_stage;

  localparam int unsigned PC_W = 32;
  localparam int unsigned IRQ_N = 3;
  localparam logic [31:0] VEC_BASE = 32'h0000_0100;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     rom_addr_o;
  logic [31:0]     ins_i;
  logic            stall_i = 1'b0, redir_i = 1'b0, eret_i = 1'b0, halt_i = 1'b0;
  logic [31:0]     redir_pc_i = '0;
  logic [2:0]      irq_i = '0;
  logic [31:0]     ins_o, pc_o, epc_o;
  logic            valid_o, int_en_o;
  logic [2:0]      irq_ack_o;

  always #5 clk = ~clk;

  // Combinational ROM: each word holds its own address plus 0x100.
  assign ins_i = rom_addr_o + 32'h100;

  if_stage #(.PC_W(PC_W), .RESET_PC('0), .IRQ_N(IRQ_N), .VEC_BASE(VEC_BASE)) dut (
    .clk(clk), .rst(rst), .rom_addr_o(rom_addr_o), .ins_i(ins_i),
    .stall_i(stall_i), .redir_i(redir_i), .redir_pc_i(redir_pc_i),
    .eret_i(eret_i), .halt_i(halt_i), .irq_i(irq_i),
`ifdef IRQ_MASK_EN
    .mask_we_i(1'b0), .mask_i(3'b111),
`endif
    .ins_o(ins_o), .pc_o(pc_o), .valid_o(valid_o), .epc_o(epc_o),
    .int_en_o(int_en_o), .irq_ack_o(irq_ack_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        vld;
    logic [31:0] epc;
    logic        ie;
    logic [2:0]  ack;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  // ---------------- behavioural model ----------------
  bit [31:0] m_pc, m_epc, m_ins, m_opc;
  bit        m_vld, m_ie, m_halted;
  int        m_shadow;
  bit        m_pend[3];
  bit        m_prev[3];
  bit [2:0]  m_ack;

  function automatic void model_step(bit r, bit s, bit rd, bit [31:0] rp,
                                     bit e, bit h, bit [2:0] irq);
    bit rise[3];
    bit taken;
    int k;
    for (int i = 0; i < 3; i++) rise[i] = irq[i] && !m_prev[i];
    taken = 0;
    m_ack = 3'b000;
    if (!r) begin
      m_pc = 0; m_epc = 0; m_ins = 0; m_opc = 0; m_vld = 0;
      m_ie = 1; m_halted = 0; m_shadow = 0;
      for (int i = 0; i < 3; i++) m_pend[i] = 0;
    end else begin
      if (m_halted || h) begin
        m_halted = 1;
        m_ins = 0; m_opc = 0; m_vld = 0;
      end else if (rd && m_shadow == 0) begin
        m_pc = rp;
        m_ins = 0; m_opc = 0; m_vld = 0;
      end else begin
        if (rd) m_epc = rp;
        k = -1;
        for (int i = 2; i >= 0; i--) if (m_pend[i]) k = i;
        if (e && !s && m_shadow == 0) begin
          m_pc = m_epc; m_ie = 1;
          m_ins = 0; m_opc = 0; m_vld = 0;
        end else if (m_ie && k >= 0 && !s) begin
          m_epc = m_pc;
          m_pc = VEC_BASE + k;
          m_ins = 0; m_opc = 0; m_vld = 0;
          m_ie = 0;
          m_ack = 3'b001 << k;
          m_pend[k] = 0;
          taken = 1;
        end else if (!s) begin
          m_ins = m_pc + 32'h100;
          m_opc = m_pc;
          m_vld = 1;
          m_pc = m_pc + 1;
        end
      end
      if (taken) m_shadow = 2;
      else if (m_shadow > 0) m_shadow--;
      for (int i = 0; i < 3; i++) if (rise[i]) m_pend[i] = 1;
    end
    for (int i = 0; i < 3; i++) m_prev[i] = irq[i];
  endfunction

  // One cycle of stimulus; expectation for the following rising edge queued.
  task automatic cyc(input bit r, input bit s, input bit rd, input bit [31:0] rp,
                     input bit e, input bit h, input bit [2:0] irq);
    obs_t x;
    @(negedge clk);
    rst = r; stall_i = s; redir_i = rd; redir_pc_i = rp;
    eret_i = e; halt_i = h; irq_i = irq;
    model_step(r, s, rd, rp, e, h, irq);
    x.addr = m_pc; x.ins = m_ins; x.pc = m_opc; x.vld = m_vld;
    x.epc = m_epc; x.ie = m_ie; x.ack = m_ack;
    exp_q.push_back(x);
  endtask

  task automatic run(input int n, input bit [2:0] irq);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, irq);
  endtask

  // ---------------- monitor ----------------
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{addr: rom_addr_o, ins: ins_o, pc: pc_o, vld: valid_o,
              epc: epc_o, ie: int_en_o, ack: irq_ack_o};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL cycle %0d outputs: got addr=%h ins=%h pc=%h v=%b epc=%h ie=%b ack=%b, expected addr=%h ins=%h pc=%h v=%b epc=%h ie=%b ack=%b",
                   cycle, a.addr, a.ins, a.pc, a.vld, a.epc, a.ie, a.ack,
                   e.addr, e.ins, e.pc, e.vld, e.epc, e.ie, e.ack);
        end
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    bit r, s, rd, e, h;
    bit [31:0] rp;
    bit [2:0] irq;

    // Reset, then sequential fetch from 0.
    cyc(0, 0, 0, 0, 0, 0, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b000);
    run(5, 3'b000);
    // Two stall cycles at PC=5, then resume.
    cyc(1, 1, 0, 0, 0, 0, 3'b000);
    cyc(1, 1, 0, 0, 0, 0, 3'b000);
    run(2, 3'b000);
    // Redirect overriding a stall.
    cyc(1, 1, 1, 32'h40, 0, 0, 3'b000);
    run(2, 3'b000);
    // Land at 0x1F, then simultaneous edges on irq[2] and irq[0].
    cyc(1, 0, 1, 32'h1F, 0, 0, 3'b000);
    cyc(1, 0, 0, 0, 0, 0, 3'b000);
    cyc(1, 0, 0, 0, 0, 0, 3'b101);
    run(3, 3'b101);
    cyc(1, 0, 0, 0, 1, 0, 3'b101);
    run(4, 3'b000);
    cyc(1, 0, 0, 0, 1, 0, 3'b000);
    run(2, 3'b000);
    // Interrupt near 0x30 followed by an older redirect inside the shadow.
    cyc(1, 0, 1, 32'h2F, 0, 0, 3'b000);
    cyc(1, 0, 0, 0, 0, 0, 3'b010);
    cyc(1, 0, 0, 0, 0, 0, 3'b010);
    cyc(1, 0, 1, 32'h80, 0, 0, 3'b000);
    cyc(1, 0, 0, 0, 1, 0, 3'b000);
    run(2, 3'b000);
    cyc(1, 0, 0, 0, 1, 0, 3'b000);
    run(2, 3'b000);
    // PC wrap.
    cyc(1, 0, 1, 32'hFFFF_FFFF, 0, 0, 3'b000);
    run(3, 3'b000);
    // Halt, then interrupt edges are latched but never taken.
    cyc(1, 0, 0, 0, 0, 1, 3'b000);
    cyc(1, 0, 0, 0, 0, 0, 3'b100);
    run(3, 3'b000);
    cyc(1, 0, 1, 32'h55, 1, 0, 3'b011);
    run(2, 3'b000);
    cyc(0, 0, 0, 0, 0, 0, 3'b000);
    run(3, 3'b000);

    // Randomized traffic.
    irq = 3'b000;
    for (int n = 0; n < 3000; n++) begin
      r  = m_halted ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 199) != 0);
      s  = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 1)
                                        : $urandom_range(0, 255);
      e  = ($urandom_range(0, 7) == 0);
      h  = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      cyc(r, s, rd, rp, e, h, irq);
    end

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
